// File: rtl/seq_detector_1011_if.sv
// Serial bit / match-pulse bundle for seq_detector_1011.
// The optional match_count signal exists only when SEQ_DET_COUNT_EN is defined.
interface seq_detector_1011_if
`ifdef SEQ_DET_COUNT_EN
  #(parameter int COUNT_W = 8)
`endif
  ();
   logic seq;   // serial data bit; "sequence" is a reserved word in SystemVerilog
   logic tick;
`ifdef SEQ_DET_COUNT_EN
   logic [COUNT_W-1:0] match_count;
`endif

   modport master (
      output seq,
      input  tick
`ifdef SEQ_DET_COUNT_EN
      , input match_count
`endif
   );

   modport slave (
      input  seq,
      output tick
`ifdef SEQ_DET_COUNT_EN
      , output match_count
`endif
   );
endinterface

// File: rtl/seq_detector_1011.sv
// Moore detector for the serial pattern 1-0-1-1. tick is high while the state is S4.
// Define SEQ_DET_COUNT_EN to add a saturating match counter on bus.match_count.
module seq_detector_1011 #(
   parameter bit OVERLAP = 1'b1
`ifdef SEQ_DET_COUNT_EN
   , parameter int COUNT_W = 8
`endif
) (
   input  logic                clk,
   input  logic                rst,
   seq_detector_1011_if.slave  bus
);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S0;
      else      state <= state_nxt;
   end

   // NOTE: next state gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = S0;
      case (state)
         S0: state_nxt = bus.seq ? S1 : S0;
         S1: state_nxt = bus.seq ? S1 : S2;
         S2: state_nxt = bus.seq ? S3 : S0;
         S3: state_nxt = bus.seq ? S4 : S2;
         S4: begin
            // Overlap keeps the trailing "1" / "10" suffix; otherwise start over.
            if (OVERLAP) state_nxt = bus.seq ? S1 : S2;
            else         state_nxt = bus.seq ? S1 : S0;
         end
         default: state_nxt = S0;
      endcase
   end

   assign bus.tick = (state == S4);

`ifdef SEQ_DET_COUNT_EN
   logic [COUNT_W-1:0] match_count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         match_count_q <= '0;
      else if ((state_nxt == S4) && (match_count_q != {COUNT_W{1'b1}}))
         match_count_q <= match_count_q + 1'b1;
   end

   assign bus.match_count = match_count_q;
`endif

endmodule

// File: tb/tb_seq_detector_1011.sv
// Scoreboard bench: one detector with overlap, one without, fed the same bit stream.
// Build with SEQ_DET_COUNT_EN defined to also check the saturating counters (COUNT_W=2).
module tb_seq_detector_1011;

   localparam int COUNT_W = 2;

   logic clk;
   logic rst;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic tick_ovl;
      logic tick_nov;
      int   cnt_ovl;
      int   cnt_nov;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: bit history since reset (or since last match when not overlapping).
   logic [3:0] hist_ovl, hist_nov;
   int         len_ovl, len_nov;
   int         cnt_ovl, cnt_nov;

`ifdef SEQ_DET_COUNT_EN
   seq_detector_1011_if #(.COUNT_W(COUNT_W)) bus_ovl ();
   seq_detector_1011_if #(.COUNT_W(COUNT_W)) bus_nov ();
   seq_detector_1011 #(.OVERLAP(1'b1), .COUNT_W(COUNT_W)) dut_ovl (.clk(clk), .rst(rst), .bus(bus_ovl.slave));
   seq_detector_1011 #(.OVERLAP(1'b0), .COUNT_W(COUNT_W)) dut_nov (.clk(clk), .rst(rst), .bus(bus_nov.slave));
`else
   seq_detector_1011_if bus_ovl ();
   seq_detector_1011_if bus_nov ();
   seq_detector_1011 #(.OVERLAP(1'b1)) dut_ovl (.clk(clk), .rst(rst), .bus(bus_ovl.slave));
   seq_detector_1011 #(.OVERLAP(1'b0)) dut_nov (.clk(clk), .rst(rst), .bus(bus_nov.slave));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      hist_ovl = '0; hist_nov = '0;
      len_ovl  = 0;  len_nov  = 0;
      cnt_ovl  = 0;  cnt_nov  = 0;
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      check({tag, "_tick_ovl"}, {31'd0, bus_ovl.tick}, {31'd0, e.tick_ovl});
      check({tag, "_tick_nov"}, {31'd0, bus_nov.tick}, {31'd0, e.tick_nov});
`ifdef SEQ_DET_COUNT_EN
      check({tag, "_cnt_ovl"}, 32'(bus_ovl.match_count), e.cnt_ovl);
      check({tag, "_cnt_nov"}, 32'(bus_nov.match_count), e.cnt_nov);
`endif
   endtask

   function automatic exp_t idle_exp();
      exp_t e;
      e.tick_ovl = 1'b0; e.tick_nov = 1'b0;
      e.cnt_ovl  = cnt_ovl; e.cnt_nov = cnt_nov;
      return e;
   endfunction

   // Drive one bit ahead of the edge, push the model's prediction, check after the edge.
   task automatic send_bit(input string tag, input logic b);
      exp_t e;
      exp_t got_e;
      @(negedge clk);
      bus_ovl.seq = b;
      bus_nov.seq = b;
      hist_ovl = {hist_ovl[2:0], b};
      hist_nov = {hist_nov[2:0], b};
      if (len_ovl < 4) len_ovl++;
      if (len_nov < 4) len_nov++;
      e.tick_ovl = (len_ovl == 4) && (hist_ovl == 4'b1011);
      e.tick_nov = (len_nov == 4) && (hist_nov == 4'b1011);
      if (e.tick_nov) len_nov = 0;
      if (e.tick_ovl && cnt_ovl < (1 << COUNT_W) - 1) cnt_ovl++;
      if (e.tick_nov && cnt_nov < (1 << COUNT_W) - 1) cnt_nov++;
      e.cnt_ovl = cnt_ovl;
      e.cnt_nov = cnt_nov;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got_e = exp_q.pop_front();
      check_outputs(tag, got_e);
   endtask

   task automatic send_stream(input string tag, input logic [15:0] bits, input int n);
      logic [15:0] v;
      v = bits;
      for (int i = n - 1; i >= 0; i--) send_bit(tag, v[i]);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      #1;
      check_outputs("rst", idle_exp());
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Reset pulse placed between edges, away from both clock edges.
   task automatic async_pulse(input string tag);
      @(posedge clk);
      #2;
      rst = 1'b0;
      model_clear();
      #1;
      check_outputs(tag, idle_exp());
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      bus_ovl.seq = 1'bx;
      bus_nov.seq = 1'bx;
      model_clear();

      // Held in reset while the input toggles.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus_ovl.seq = i[0];
         bus_nov.seq = i[0];
         @(posedge clk);
         #1;
         check_outputs("hold_rst", idle_exp());
      end
      @(negedge clk);
      rst = 1'b1;
      send_bit("post_rst", 1'b0);

      send_stream("basic", 16'b10110, 5);
      apply_reset();
      send_stream("ovl_a", 16'b1011011, 7);
      apply_reset();
      send_stream("ovl_b", 16'b10111011, 8);
      apply_reset();
      send_stream("reuse10", 16'b101011, 6);
      apply_reset();
      send_stream("near_miss", 16'b1100100111, 10);

      // Partial progress discarded by a mid-sequence asynchronous reset.
      apply_reset();
      send_stream("mid_pre", 16'b101, 3);
      async_pulse("mid_rst");
      send_stream("mid_post", 16'b1, 1);
      send_stream("mid_tail", 16'b011, 3);
      send_stream("fresh", 16'b10110, 5);

      // tick clears immediately when reset asserts while it is high.
      apply_reset();
      send_stream("pre_clr", 16'b1011, 4);
      async_pulse("async_clr");

      // Five back-to-back matches drive the narrow counters into saturation.
      apply_reset();
      for (int m = 0; m < 5; m++) send_stream("count", 16'b1011, 4);
      apply_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
